bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) producing the packed
//   BCD digits consumed by the per-digit bcd_to_7seg decoders of the stopwatch display.
//   Takes one binary count value per start request and returns DIGITS BCD digits.
//   One bit is processed per clock, so area stays small at the cost of BIN_W cycles of latency.
// PARAMETERS
//   BIN_W   14  width of binary input; 14 covers 0..9999 (legal range 1..32)
//   DIGITS  4   number of BCD output digits (legal range 1..9)
// PORTS
//   clk       in   1           system clock, all logic on rising edge
//   rst       in   1           synchronous, active-high reset
//   start     in   1           conversion request, sampled only while idle
//   bin_in    in   BIN_W       binary value, captured on the accepting edge
//   busy      out  1           high while a conversion is in progress
//   done      out  1           one-cycle pulse: bcd_out/overflow just updated
//   bcd_out   out  4*DIGITS    packed BCD; digit k at [4k+3:4k], digit 0 = units
//   overflow  out  1           captured bin_in was greater than 10^DIGITS-1
// BEHAVIOUR
//   Interface: one clock (clk). Reset rst is synchronous and active-high.
//   Reset: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, internal shift/scratch regs=0.
//   Reset mid-conversion aborts it: no done pulse is produced and bcd_out is cleared to 0.
//   FSM states: IDLE and SHIFT.
//     IDLE -> SHIFT when start=1 at a rising edge N.
//       On that edge: latch bin_in, clear the BCD scratch, load bit counter = BIN_W.
//       Also latch ovf_pend = (bin_in > 10^DIGITS-1).
//     SHIFT: one iteration per edge, at edges N+1 .. N+BIN_W.
//       Each iteration: every scratch digit >= 5 gets +3 (4-bit result, all digits in parallel).
//       Then {scratch, bin} shifts left by 1; the bit shifted out of the top digit is discarded.
//     SHIFT -> IDLE on edge N+BIN_W (counter reaches 0).
//       On that same edge: bcd_out <= final scratch, overflow <= ovf_pend, done <= 1.
//   busy=1 for exactly BIN_W cycles (after edges N .. N+BIN_W-1); busy=0 whenever state=IDLE.
//   done is high for exactly one cycle, after edge N+BIN_W; it is otherwise 0.
//   Latency: start accepted at edge N -> done visible after edge N+BIN_W.
//   start while busy is ignored: not queued, bin_in not re-sampled.
//   start held high through the done cycle is accepted at edge N+BIN_W+1.
//     Back-to-back throughput: one conversion per BIN_W+1 cycles.
//   bcd_out and overflow hold their last values between done pulses.
//     They are never updated mid-conversion, so the display never sees partial digits.
//   Out-of-range input (overflow=1): bcd_out = bin_in mod 10^DIGITS, i.e. the low DIGITS digits.
//     This follows naturally from dropping the top-digit carry.
//   bin_in = 0 converts normally: all-zero digits, overflow=0, full BIN_W latency.
//   Every output digit is 0..9 for any input; no digit is ever 0xA..0xF.
// TESTING
//   Default params, rst for 2 cycles -> busy=0, done=0, bcd_out=16'h0000, overflow=0.
//   start with bin_in=1234 -> done exactly 14 cycles after accept, bcd_out=16'h1234, overflow=0.
//   bin_in=9999, then 0, back-to-back (start held high) -> 16'h9999 then 16'h0000.
//     done pulses are 15 cycles apart.
//   bin_in=12345 -> bcd_out=16'h2345, overflow=1.
//     Next conversion with bin_in=42 -> 16'h0042, overflow=0.
//   Pulse start with bin_in=500, then pulse start with bin_in=77 at cycle 5 of the conversion.
//     -> single done pulse, bcd_out=16'h0500, no second conversion.
//   Assert rst at cycle 7 of a conversion of 8888 -> no done pulse, bcd_out=0, busy=0.
//     New conversion of 8888 afterwards -> 16'h8888.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3).
//                Converts one binary value per start request into DIGITS
//                packed BCD digits, processing one input bit per clock.
//
//  Ports
//    clk       in   1          system clock, rising edge
//    rst       in   1          synchronous, active-high reset
//    start     in   1          conversion request, sampled only while idle
//    bin_in    in   BIN_W      binary value, captured on the accepting edge
//    busy      out  1          high while a conversion is in progress
//    done      out  1          one-cycle pulse: bcd_out/overflow just updated
//    bcd_out   out  4*DIGITS   packed BCD, digit k at [4k+3:4k], digit 0 = units
//    overflow  out  1          captured bin_in exceeded 10^DIGITS-1
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // Elaboration-time 10^n; 64 bits is ample for DIGITS up to 9.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] c_max_val = pow10(DIGITS) - 64'd1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [c_cnt_w-1:0]   cnt_q,      cnt_d;
    logic [BIN_W-1:0]     bin_q,      bin_d;
    logic [c_bcd_w-1:0]   scratch_q,  scratch_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [c_bcd_w-1:0]   bcd_q,      bcd_d;
    logic                 ovf_q,      ovf_d;
    logic                 done_q,     done_d;

    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_shift;
    logic                 w_ovf_in;

    // Add-3 correction on every digit in parallel; 4-bit wrap is safe since
    // a digit is at most 9 here, so the result never exceeds 12.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign w_adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5)
                               ? scratch_q[4*k +: 4] + 4'd3
                               : scratch_q[4*k +: 4];
    end

    // Shift the corrected scratch left, pulling in the next binary MSB. The
    // carry out of the top digit is dropped, which yields bin mod 10^DIGITS.
    assign w_shift  = c_bcd_w'({w_adj, bin_q[BIN_W-1]});
    assign w_ovf_in = 64'(bin_in) > c_max_val;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SHIFT;
                    bin_d      = bin_in;
                    scratch_d  = '0;
                    cnt_d      = c_cnt_load;
                    ovf_pend_d = w_ovf_in;
                end
            end
            S_SHIFT: begin
                scratch_d = w_shift;
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q - c_cnt_one;
                // Last iteration: publish the completed digits atomically.
                if (cnt_q == c_cnt_one) begin
                    state_d = S_IDLE;
                    bcd_d   = w_shift;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Scoreboard bench for bin_to_bcd_seq. Stimulus pushes the
//                hand-computed expected digits and accept cycle; a monitor
//                pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [BIN_W-1:0]   bin_in;
    logic               busy;
    logic               done;
    logic [15:0]        bcd_out;
    logic               overflow;

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_done_cyc = -1;
    int   done_gap      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("latency", 32'(cyc - e.acc), 32'(BIN_W));
                for (int d = 0; d < DIGITS; d++) begin
                    check("digit_le_9", 32'(bcd_out[4*d +: 4] <= 4'd9), 32'd1);
                end
            end
        end
    end

    // Called at a negedge while the DUT is idle: the next posedge accepts.
    task automatic issue(input logic [BIN_W-1:0] val, input logic [15:0] exp_bcd, input logic exp_ovf);
        exp_t e;
        start  = 1'b1;
        bin_in = val;
        e.bcd  = exp_bcd;
        e.ovf  = exp_ovf;
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic convert(input logic [BIN_W-1:0] val, input logic [15:0] exp_bcd, input logic exp_ovf);
        issue(val, exp_bcd, exp_ovf);
        repeat (BIN_W + 1) @(negedge clk);
    endtask

    logic [BIN_W-1:0] vec_in  [5] = '{14'd1234, 14'd7, 14'd10000, 14'd16383, 14'd9998};
    logic [15:0]      vec_bcd [5] = '{16'h1234, 16'h0007, 16'h0000, 16'h6383, 16'h9998};
    logic             vec_ovf [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        exp_t e;
        int   c0;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, including range boundaries.
        for (int i = 0; i < 5; i++) begin
            convert(vec_in[i], vec_bcd[i], vec_ovf[i]);
        end

        // Back-to-back with start held: 9999 then 0.
        c0     = cyc;
        start  = 1'b1;
        bin_in = 14'd9999;
        e.bcd = 16'h9999; e.ovf = 1'b0; e.acc = c0 + 1;
        sb.push_back(e);
        @(negedge clk);
        bin_in = 14'd0;
        e.bcd = 16'h0000; e.ovf = 1'b0; e.acc = c0 + 1 + BIN_W + 1;
        sb.push_back(e);
        repeat (BIN_W + 1) @(negedge clk);
        start = 1'b0;
        repeat (BIN_W + 2) @(negedge clk);
        check("b2b_done_gap", 32'(done_gap), 32'(BIN_W + 1));
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Overflow case, then an in-range value; outputs hold mid-conversion.
        convert(14'd12345, 16'h2345, 1'b1);
        issue(14'd42, 16'h0042, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_hold_bcd", 32'(bcd_out), 32'h2345);
        check("mid_hold_ovf", 32'(overflow), 32'd1);
        repeat (BIN_W + 1 - 5) @(negedge clk);

        // A start pulse while busy is ignored.
        issue(14'd500, 16'h0500, 1'b0);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd77;
        @(negedge clk);
        start  = 1'b0;
        repeat (40) @(negedge clk);
        check("ignored_start_idle", 32'(busy), 32'd0);
        check("ignored_start_drained", 32'(sb.size()), 32'd0);
        check("ignored_start_bcd", 32'(bcd_out), 32'h0500);

        // Reset mid-conversion aborts without a done pulse.
        start  = 1'b1;
        bin_in = 14'd8888;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h0);
        check("abort_ovf", 32'(overflow), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_bcd_after", 32'(bcd_out), 32'h0);
        convert(14'd8888, 16'h8888, 1'b0);

        repeat (3) @(negedge clk);
        check("final_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
